seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative signed restoring divider. It is the responder side of the data_rdy/res_rdy divide handshake that the position-calculation FSMs use as initiator.
- Accepts a one-cycle data_rdy request with dividend/divisor and produces one quotient bit per clock.
- Returns merchant/remainder with a one-cycle res_rdy pulse.
- Shared by distance, R, x/y and 2D-projection calculations, one request at a time.

Parameters:
- N, 32, dividend/merchant/remainder width (signed two's complement).
- M, 32, divisor width (signed); M <= N.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data_rdy  in  1  request strobe; operands sampled on the rising edge where it is high and the block is not busy
- dividend  in  N  signed dividend
- divisor  in  M  signed divisor
- busy  out  1  high while a division is in progress
- res_rdy  out  1  single-cycle result-valid pulse
- merchant  out  N  signed quotient
- remainder  out  N  signed remainder
- div_zero  out  1  high alongside the result when divisor was 0

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, res_rdy=0, merchant=0, remainder=0, div_zero=0; counter and working registers cleared. Reset mid-operation aborts the division; no res_rdy is produced.
- States: IDLE, CALC, FIX.
- IDLE: on an edge with data_rdy=1, latch sign flags (dividend MSB, divisor MSB), |dividend| (N bits, unsigned), |divisor| sign-extended to N bits, and a zero flag. Clear the partial remainder and counter; busy<=1; go to CALC.
- CALC: exactly N cycles, one restoring step each, MSB of dividend first.
  - Shift {rem, quo} left 1.
  - Trial-subtract |divisor| from rem using an N+1-bit subtractor.
  - Keep the difference and set the quotient LSB when it is non-negative.
  - Counter runs 0..N-1; after step N-1, go to FIX.
- FIX (1 cycle): apply signs, then register outputs and return to IDLE.
  - Quotient negated if the sign flags differ.
  - Remainder takes the dividend's sign.
  - Truncation toward zero, matching Verilog signed / and %.
  - On the FIX edge: merchant, remainder, div_zero registered; res_rdy<=1; busy<=0; state<=IDLE.
- Latency: data_rdy sampled at edge t -> res_rdy high during the cycle following edge t+N+1 (N+1 clocks; 33 for N=32).
- res_rdy: high exactly one cycle, cleared on the next edge regardless of inputs. It is never high two consecutive cycles, so an initiator entering its wait state one cycle after issuing data_rdy never sees a stale pulse.
- merchant/remainder/div_zero: hold their values until the next result is registered (stable after res_rdy drops).
- data_rdy while busy=1: ignored, operands not re-sampled, no error.
- data_rdy in the res_rdy cycle (state already IDLE): accepted; back-to-back operation allowed.
- Divisor 0: runs the full N+1 latency. Result is merchant = all ones, remainder = dividend, div_zero=1.
- Overflow case -2^(N-1) / -1: the magnitude is not representable. merchant wraps to -2^(N-1), remainder=0, div_zero=0.
- |dividend| of -2^(N-1) is handled as unsigned 2^(N-1); no loss.
- Divisor narrower than N: sign-extended before taking magnitude.

Test Plan:
- N=M=32, dividend=17000000, divisor=93750, 1-cycle data_rdy -> res_rdy exactly 33 clocks later, one cycle wide; merchant=181, remainder=31250, div_zero=0, busy high 33 cycles.
- Sign matrix with ±100/±7 -> (100,7)=14,2; (-100,7)=-14,-2; (100,-7)=-14,2; (-100,-7)=14,-2; also 5/7 gives merchant=0, remainder=5.
- Divisor 0 with dividend=-55 -> after 33 clocks merchant=32'hFFFFFFFF, remainder=-55, div_zero=1; next valid division clears div_zero.
- data_rdy re-pulsed with new operands 10 cycles into a division -> ignored; first result unchanged and on time. Then a data_rdy in the res_rdy cycle -> accepted; its result arrives 33 clocks later.
- rst asserted mid-CALC (cycle 15) with no clock edge -> outputs zero immediately, no res_rdy. After release, 0x80000000 / -1 -> merchant=0x80000000, remainder=0.
- Random signed operands (non-zero divisor, 1000 iterations) compared against the reference model's / and % -> all match, latency constant.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative signed restoring divider: one quotient bit per clock, truncating toward zero.
// Answers a one-cycle data_rdy request with merchant/remainder and a one-cycle res_rdy pulse.
module seq_divider #(
    parameter int N = 32,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_rdy,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         res_rdy,
    output logic [N-1:0] merchant,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic          dnd_neg_q, dnd_neg_d;
    logic          dvs_neg_q, dvs_neg_d;
    logic          zero_q, zero_d;
    logic          busy_q, busy_d;
    logic          res_rdy_q, res_rdy_d;
    logic [N-1:0]  merchant_q, merchant_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          div_zero_q, div_zero_d;

    logic [N-1:0]  divisor_ext;
    logic [N-1:0]  dividend_mag;
    logic [N-1:0]  divisor_mag;
    logic [N:0]    shifted;
    logic [N:0]    diff;

    // Magnitudes are unsigned N-bit values, so -2^(N-1) maps cleanly to 2^(N-1).
    assign divisor_ext  = N'($signed(divisor));
    assign dividend_mag = dividend[N-1] ? (~dividend + N'(1)) : dividend;
    assign divisor_mag  = divisor_ext[N-1] ? (~divisor_ext + N'(1)) : divisor_ext;

    // The partial remainder stays below |divisor|, so one extra bit holds the shifted value.
    assign shifted = {rem_q, quo_q[N-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dnd_neg_d   = dnd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        res_rdy_d   = 1'b0;
        merchant_d  = merchant_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (data_rdy) begin
                    dnd_neg_d = dividend[N-1];
                    dvs_neg_d = divisor_ext[N-1];
                    zero_d    = (divisor == '0);
                    quo_d     = dividend_mag;
                    dvs_d     = divisor_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (!diff[N]) begin
                    rem_d = diff[N-1:0];
                end else begin
                    rem_d = shifted[N-1:0];
                end
                quo_d = {quo_q[N-2:0], ~diff[N]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A zero divisor leaves rem = |dividend|, so the sign fix restores the dividend.
                if (zero_q) begin
                    merchant_d = '1;
                end else if (dnd_neg_q ^ dvs_neg_q) begin
                    merchant_d = -quo_q;
                end else begin
                    merchant_d = quo_q;
                end
                remainder_d = dnd_neg_q ? -rem_q : rem_q;
                div_zero_d  = zero_q;
                res_rdy_d   = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dnd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            res_rdy_q   <= 1'b0;
            merchant_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dnd_neg_q   <= dnd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            res_rdy_q   <= res_rdy_d;
            merchant_q  <= merchant_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = busy_q;
    assign res_rdy   = res_rdy_q;
    assign merchant  = merchant_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule
